xres_reset_sequencer: RTL and testbench
=======================================

// Module: xres_reset_sequencer
// PURPOSE
//   Consumes the level-shifted external reset from the XRES pad cell (XRES_H_N ->
//   xres_n_in). Synchronises it, glitch-filters it, merges it with a housekeeping
//   soft-reset request, and releases the staged chip resets (core, peripheral,
//   user) in a fixed order. Records the cause of the last reset.
// PARAMETERS
//   SYNC_STAGES  2   synchroniser flops on xres_n_in (>=2)
//   FILT_CYCLES  16  consecutive stable synced cycles needed to change ext_reset_n (>=1)
//   HOLD_CYCLES  32  cycles in ASSERT after ext_reset_n=1 before rst_core_n release (>=1)
//   STAGE_GAP    8   cycles between successive stage releases (>=1)
//   CNT_W        8   width of filter/sequence counters; must hold max(FILT,HOLD,GAP)
// PORTS
//   clock           in   1  system clock
//   resetb          in   1  async active-low power-on reset
//   xres_n_in       in   1  async external reset from pad, active low
//   filt_bypass     in   1  1 = ext_reset_n follows synced value, no filter
//   soft_reset_req  in   1  1-cycle pulse from housekeeping, requests full reset
//   cause_clear     in   1  1-cycle pulse, clears reset_cause
//   ext_reset_n     out  1  synchronised, filtered external reset level
//   rst_core_n      out  1  core reset, active low, released first
//   rst_periph_n    out  1  peripheral reset, released second
//   rst_user_n      out  1  user-area reset, released last
//   reset_cause     out  2  00 none/cleared, 01 POR, 10 XRES, 11 soft
//   busy            out  1  1 whenever state != RUN
// BEHAVIOUR
//   Reset (resetb=0, async): sync flops=0, ext_reset_n=0, rst_*_n=0, state=ASSERT,
//     counters=0, reset_cause=01, busy=1. The deassertion of resetb is not itself
//     synchronised here; it is synchronised upstream.
//   Synchroniser: SYNC_STAGES flops, output xs.
//   Filter: filt_cnt counts cycles in which xs != ext_reset_n; it clears when xs ==
//     ext_reset_n. When filt_cnt == FILT_CYCLES-1 and xs still differs, ext_reset_n <= xs
//     and filt_cnt <= 0 on that edge. A mismatch of exactly FILT_CYCLES cycles toggles the
//     output; FILT_CYCLES-1 cycles does not. With filt_bypass=1, ext_reset_n <= xs every
//     cycle and filt_cnt is held at 0.
//   Reset entry event: ext_reset_n falls (registered 1->0) OR soft_reset_req=1.
//     - From any state, the FSM enters ASSERT and seq_cnt <= 0.
//     - All rst_*_n go 0 on that same edge (registered outputs).
//   FSM states: ASSERT -> REL_CORE -> REL_PERIPH -> RUN.
//     ASSERT: all rst_*_n=0. seq_cnt counts while ext_reset_n=1, and holds at 0 while
//       ext_reset_n=0. At seq_cnt==HOLD_CYCLES-1: rst_core_n<=1, state<=REL_CORE, seq_cnt<=0.
//     REL_CORE: at seq_cnt==STAGE_GAP-1: rst_periph_n<=1, state<=REL_PERIPH, seq_cnt<=0.
//     REL_PERIPH: at seq_cnt==STAGE_GAP-1: rst_user_n<=1, state<=RUN.
//     RUN: all outputs 1, busy=0. Leaves only on a reset entry event.
//   Timing: rst_core_n rises HOLD_CYCLES edges after the edge on which ext_reset_n rises.
//     rst_periph_n follows STAGE_GAP edges later; rst_user_n another STAGE_GAP later.
//   Ordering invariant: rst_user_n=1 implies rst_periph_n=1; rst_periph_n=1 implies
//     rst_core_n=1. Holds in every cycle.
//   ext_reset_n=0 persisting: the FSM stays in ASSERT with seq_cnt=0 (level-held reset).
//   A soft request during ASSERT restarts seq_cnt at 0.
//   reset_cause: on an entry event it is loaded with 10 for XRES and 11 for soft.
//     If both occur on the same edge, XRES wins (10).
//     cause_clear sets 00, unless an entry event occurs on the same edge, in which case
//     the event value is loaded.
//   Counters saturate; they never wrap.
// TESTING
//   1 POR, defaults, xres_n_in=1 held, resetb released at edge 0 -> ext_reset_n=1 @ edge 18,
//     rst_core_n @ 50, rst_periph_n @ 58, rst_user_n @ 66, busy=0 @ 66, cause=01.
//   2 In RUN, xres_n_in low 15 cycles -> no output change. Low 20 cycles -> all rst_*_n=0
//     1 edge after ext_reset_n falls, cause=10; re-release follows test-1 spacing.
//   3 In RUN, soft_reset_req pulse -> all rst_*_n=0 next edge, cause=11. Release after
//     32/40/48 edges.
//   4 soft_reset_req on the same edge ext_reset_n falls -> cause=10. cause_clear with no
//     event -> 00. cause_clear plus soft on the same edge -> 11.
//   5 resetb pulsed low while in REL_CORE -> all outputs 0 asynchronously, cause=01,
//     full sequence restarts.
//   6 filt_bypass=1, 3-cycle xres low glitch in RUN -> reset entered, cause=10.
//     Ordering invariant asserted in every test.

Source files
------------

// File: rtl/xres_reset_sequencer.sv
// xres_reset_sequencer
// Takes the level-shifted XRES pad reset, synchronises and glitch-filters it,
// and merges it with the housekeeping soft-reset request. It then releases the
// chip resets in a fixed order (core, peripheral, user) and records what caused
// the most recent reset.
module xres_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 16,
  parameter int HOLD_CYCLES = 32,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       xres_n_in,
  input  logic       filt_bypass,
  input  logic       soft_reset_req,
  input  logic       cause_clear,
  output logic       ext_reset_n,
  output logic       rst_core_n,
  output logic       rst_periph_n,
  output logic       rst_user_n,
  output logic [1:0] reset_cause,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_ASSERT     = 2'd0,
    ST_REL_CORE   = 2'd1,
    ST_REL_PERIPH = 2'd2,
    ST_RUN        = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_XRES = 2'b10;
  localparam logic [1:0] CAUSE_SOFT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] FILT_END = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(STAGE_GAP - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   xs;
  logic [CNT_W-1:0]       filt_cnt_q, filt_cnt_d;
  logic                   ext_q, ext_d;
  logic                   ext_prev_q;
  logic                   ext_fall;
  logic                   entry;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       seq_cnt_q, seq_cnt_d;
  logic                   rst_core_q, rst_periph_q, rst_user_q;
  logic [1:0]             cause_q, cause_d;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Shift the asynchronous pad level through the synchroniser chain.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= xres_n_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign xs = sync_q[SYNC_STAGES-1];

  // Glitch filter: the output only follows xs after FILT_CYCLES consecutive mismatches.
  always_comb begin
    ext_d      = ext_q;
    filt_cnt_d = filt_cnt_q;
    if (filt_bypass) begin
      ext_d      = xs;
      filt_cnt_d = '0;
    end else if (xs == ext_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FILT_END) begin
      ext_d      = xs;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = sat_inc(filt_cnt_q);
    end
  end

  // A registered 1->0 of the filtered level, or a soft request, restarts the sequence.
  assign ext_fall = ext_prev_q & ~ext_q;
  assign entry    = ext_fall | soft_reset_req;

  // Sequencer next state: hold in ASSERT while the external reset is low, then stage releases.
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    case (state_q)
      ST_ASSERT: begin
        if (!ext_q) begin
          seq_cnt_d = '0;
        end else if (seq_cnt_q == HOLD_END) begin
          state_d   = ST_REL_CORE;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = sat_inc(seq_cnt_q);
        end
      end
      ST_REL_CORE: begin
        if (seq_cnt_q == GAP_END) begin
          state_d   = ST_REL_PERIPH;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = sat_inc(seq_cnt_q);
        end
      end
      ST_REL_PERIPH: begin
        if (seq_cnt_q == GAP_END) begin
          state_d   = ST_RUN;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = sat_inc(seq_cnt_q);
        end
      end
      default: begin
        seq_cnt_d = '0;
      end
    endcase
    if (entry) begin
      state_d   = ST_ASSERT;
      seq_cnt_d = '0;
    end
  end

  // Reset cause: an XRES event beats a simultaneous soft request; any event beats a clear.
  always_comb begin
    cause_d = cause_q;
    if (ext_fall) begin
      cause_d = CAUSE_XRES;
    end else if (soft_reset_req) begin
      cause_d = CAUSE_SOFT;
    end else if (cause_clear) begin
      cause_d = CAUSE_NONE;
    end
  end

  // State, counters and staged reset outputs; the outputs are decoded from the next
  // state so that release order is guaranteed by construction.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      filt_cnt_q   <= '0;
      ext_q        <= 1'b0;
      ext_prev_q   <= 1'b0;
      state_q      <= ST_ASSERT;
      seq_cnt_q    <= '0;
      rst_core_q   <= 1'b0;
      rst_periph_q <= 1'b0;
      rst_user_q   <= 1'b0;
      cause_q      <= CAUSE_POR;
    end else begin
      filt_cnt_q   <= filt_cnt_d;
      ext_q        <= ext_d;
      ext_prev_q   <= ext_q;
      state_q      <= state_d;
      seq_cnt_q    <= seq_cnt_d;
      rst_core_q   <= (state_d != ST_ASSERT);
      rst_periph_q <= (state_d == ST_REL_PERIPH) || (state_d == ST_RUN);
      rst_user_q   <= (state_d == ST_RUN);
      cause_q      <= cause_d;
    end
  end

  assign ext_reset_n  = ext_q;
  assign rst_core_n   = rst_core_q;
  assign rst_periph_n = rst_periph_q;
  assign rst_user_n   = rst_user_q;
  assign reset_cause  = cause_q;
  assign busy         = (state_q != ST_RUN);

endmodule

// File: tb/tb_xres_reset_sequencer.sv
// Directed bench for xres_reset_sequencer with default parameters.
// Edge numbers are counted from the edge just before the stimulus change (edge 0).
module tb_xres_reset_sequencer;

  logic       clock = 1'b0;
  logic       resetb = 1'b1;
  logic       xres_n_in = 1'b1;
  logic       filt_bypass = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       cause_clear = 1'b0;
  logic       ext_reset_n;
  logic       rst_core_n;
  logic       rst_periph_n;
  logic       rst_user_n;
  logic [1:0] reset_cause;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  xres_reset_sequencer dut (
    .clock          (clock),
    .resetb         (resetb),
    .xres_n_in      (xres_n_in),
    .filt_bypass    (filt_bypass),
    .soft_reset_req (soft_reset_req),
    .cause_clear    (cause_clear),
    .ext_reset_n    (ext_reset_n),
    .rst_core_n     (rst_core_n),
    .rst_periph_n   (rst_periph_n),
    .rst_user_n     (rst_user_n),
    .reset_cause    (reset_cause),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input bit quiet = 1'b0);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[%0t] FAIL %s: got %0d expected %0d", $time, tag, got, exp);
    end else if (!quiet) begin
      $display("[%0t] ok   %s: got %0d expected %0d", $time, tag, got, exp);
    end
  endtask

  // Release order and busy flag are checked on every falling edge.
  always @(negedge clock) begin
    check("order", {31'd0, (!rst_user_n || rst_periph_n) && (!rst_periph_n || rst_core_n)},
          32'd1, 1'b1);
    check("busy_vs_user", {31'd0, busy}, {31'd0, !rst_user_n}, 1'b1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs up to budget edges and records the first edge at which each output is high.
  task automatic run_seq(input int budget, output int t_ext, output int t_core,
                         output int t_per, output int t_user, output int t_idle);
    t_ext = -1; t_core = -1; t_per = -1; t_user = -1; t_idle = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (t_ext  < 0 && ext_reset_n)  t_ext  = i;
      if (t_core < 0 && rst_core_n)   t_core = i;
      if (t_per  < 0 && rst_periph_n) t_per  = i;
      if (t_user < 0 && rst_user_n)   t_user = i;
      if (t_idle < 0 && !busy)        t_idle = i;
      if (t_user >= 0) break;
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_ext"},    {31'd0, ext_reset_n},  32'd0);
    check({tag, "_core"},   {31'd0, rst_core_n},   32'd0);
    check({tag, "_periph"}, {31'd0, rst_periph_n}, 32'd0);
    check({tag, "_user"},   {31'd0, rst_user_n},   32'd0);
    check({tag, "_busy"},   {31'd0, busy},         32'd1);
  endtask

  initial begin
    int te, tc, tp, tu, ti;
    int t_ef, t_cf, t_er, t_cr, t_ur, k;
    bit changed;

    // 1: power-on reset and default release timing
    #1 resetb = 1'b0;
    repeat (3) tick();
    check_all_low("por");
    check("por_cause", {30'd0, reset_cause}, 32'd1);
    resetb = 1'b1;
    run_seq(100, te, tc, tp, tu, ti);
    check("t1_ext_edge",    te, 18);
    check("t1_core_edge",   tc, 50);
    check("t1_periph_edge", tp, 58);
    check("t1_user_edge",   tu, 66);
    check("t1_idle_edge",   ti, 66);
    check("t1_cause", {30'd0, reset_cause}, 32'd1);

    // 2: 15-cycle pad glitch is filtered, 20-cycle low resets
    repeat (5) tick();
    changed = 1'b0;
    xres_n_in = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      tick();
      if (i == 15) xres_n_in = 1'b1;
      if (!ext_reset_n || !rst_user_n) changed = 1'b1;
    end
    check("t2_glitch15_ignored", {31'd0, changed}, 32'd0);
    xres_n_in = 1'b0;
    t_ef = -1; t_cf = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (t_ef < 0 && !ext_reset_n) t_ef = i;
      if (t_cf < 0 && !rst_core_n)  t_cf = i;
    end
    check("t2_ext_fall_edge",  t_ef, 18);
    check("t2_core_fall_edge", t_cf, 19);
    check("t2_user_low", {31'd0, rst_user_n}, 32'd0);
    check("t2_cause", {30'd0, reset_cause}, 32'd2);
    xres_n_in = 1'b1;
    run_seq(100, te, tc, tp, tu, ti);
    check("t2_ext_edge",    te, 18);
    check("t2_core_edge",   tc, 50);
    check("t2_periph_edge", tp, 58);
    check("t2_user_edge",   tu, 66);

    // 3: soft reset from RUN
    repeat (3) tick();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    check("t3_core_low",   {31'd0, rst_core_n},   32'd0);
    check("t3_periph_low", {31'd0, rst_periph_n}, 32'd0);
    check("t3_user_low",   {31'd0, rst_user_n},   32'd0);
    check("t3_cause", {30'd0, reset_cause}, 32'd3);
    run_seq(100, te, tc, tp, tu, ti);
    check("t3_core_edge",   tc, 32);
    check("t3_periph_edge", tp, 40);
    check("t3_user_edge",   tu, 48);

    // 4: cause priority and clearing
    repeat (3) tick();
    xres_n_in = 1'b0;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!ext_reset_n) begin k = i; break; end
    end
    check("t4_ext_fall_edge", k, 18);
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    check("t4_both_cause", {30'd0, reset_cause}, 32'd2);
    check("t4_core_low", {31'd0, rst_core_n}, 32'd0);
    cause_clear = 1'b1;
    tick();
    cause_clear = 1'b0;
    check("t4_clear_cause", {30'd0, reset_cause}, 32'd0);
    cause_clear = 1'b1;
    soft_reset_req = 1'b1;
    tick();
    cause_clear = 1'b0;
    soft_reset_req = 1'b0;
    check("t4_clear_soft_cause", {30'd0, reset_cause}, 32'd3);
    // soft request part way through ASSERT restarts the hold count
    xres_n_in = 1'b1;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ext_reset_n) begin k = i; break; end
    end
    check("t4_ext_rise_edge", k, 18);
    repeat (10) tick();
    check("t4_core_held", {31'd0, rst_core_n}, 32'd0);
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    run_seq(100, te, tc, tp, tu, ti);
    check("t4_restart_core_edge", tc, 32);
    check("t4_restart_user_edge", tu, 48);

    // 5: power-on reset in REL_CORE
    repeat (3) tick();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    repeat (34) tick();
    check("t5_core_released", {31'd0, rst_core_n},   32'd1);
    check("t5_periph_held",   {31'd0, rst_periph_n}, 32'd0);
    resetb = 1'b0;
    #1;
    check_all_low("t5_async");
    check("t5_cause", {30'd0, reset_cause}, 32'd1);
    tick();
    resetb = 1'b1;
    run_seq(100, te, tc, tp, tu, ti);
    check("t5_ext_edge",  te, 18);
    check("t5_core_edge", tc, 50);
    check("t5_user_edge", tu, 66);
    check("t5_cause_after", {30'd0, reset_cause}, 32'd1);

    // 6: filter bypass lets a 3-cycle glitch through
    filt_bypass = 1'b1;
    repeat (3) tick();
    xres_n_in = 1'b0;
    t_ef = -1; t_cf = -1; t_er = -1; t_cr = -1; t_ur = -1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 3) xres_n_in = 1'b1;
      if (t_ef < 0 && !ext_reset_n) t_ef = i;
      if (t_cf < 0 && !rst_core_n)  t_cf = i;
      if (t_ef >= 0 && t_er < 0 && ext_reset_n) t_er = i;
      if (t_cf >= 0 && t_cr < 0 && rst_core_n)  t_cr = i;
      if (t_cf >= 0 && t_ur < 0 && rst_user_n)  t_ur = i;
    end
    check("t6_ext_fall_edge",  t_ef, 3);
    check("t6_core_fall_edge", t_cf, 4);
    check("t6_ext_rise_edge",  t_er, 6);
    check("t6_core_rise_edge", t_cr, 38);
    check("t6_user_rise_edge", t_ur, 54);
    check("t6_cause", {30'd0, reset_cause}, 32'd2);
    filt_bypass = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
